// File: rtl/cam_pkg.sv
// Shared types and constants for the CAM multi-match iterator.
// Optional feature macro used by cam_match_iter: CAM_MATCH_COUNT_EN.
// Holds the iterator state enum, table geometry and a popcount helper.
package cam_pkg;

  localparam int CAM_ENTRIES = 8;
  localparam int CAM_ADDR_W  = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    MISS = 2'd2
  } cam_iter_state_t;

  // Number of set match lines in a vector (0..CAM_ENTRIES).
  function automatic logic [3:0] popcnt8(input logic [CAM_ENTRIES-1:0] v);
    logic [3:0] c;
    c = 4'd0;
    for (int i = 0; i < CAM_ENTRIES; i++) begin
      c = c + {3'd0, v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/cam_match_iter_prienc.sv
// prienc_8_3: LSB-priority 8-to-3 encoder, purely combinational.
// Latency: zero cycles.  Backpressure: none (no handshake).
// An all-zero input encodes to 0; the caller qualifies that case itself.
module prienc_8_3
  import cam_pkg::*;
(
  input  logic [CAM_ENTRIES-1:0] i_vec,
  output logic [CAM_ADDR_W-1:0]  o_addr
);

  // Scan from the top down so the lowest set bit is the last write and wins.
  always_comb begin
    o_addr = '0;
    for (int i = CAM_ENTRIES - 1; i >= 0; i--) begin
      if (i_vec[i]) begin
        o_addr = CAM_ADDR_W'(i);
      end
    end
  end

endmodule

// File: rtl/cam_match_iter.sv
// cam_match_iter: turns one 8-bit match vector into one beat per set bit, lowest index first.
// Latency: vector accepted at edge N gives its first beat in cycle N+1; k set bits take k handshakes.
// Backpressure: beats hold stable while hit_ready is low; match_ready is high in IDLE or on a last-beat handshake.
// Optional CAM_MATCH_COUNT_EN adds match_cnt, the popcount of the most recently accepted vector.
module cam_match_iter
  import cam_pkg::*;
#(
  parameter bit EMIT_MISS = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   match_valid,
  output logic                   match_ready,
  input  logic [CAM_ENTRIES-1:0] match_vec,
  output logic                   hit_valid,
  input  logic                   hit_ready,
  output logic [CAM_ADDR_W-1:0]  hit_addr,
  output logic                   hit_last,
  output logic                   hit_miss,
  output logic                   busy
`ifdef CAM_MATCH_COUNT_EN
  ,
  output logic [3:0]             match_cnt
`endif
);

  cam_iter_state_t        r_state;
  logic [CAM_ENTRIES-1:0] r_pend;

  logic [CAM_ENTRIES-1:0] w_pend_rest;
  logic                   w_iter_last;
  logic [CAM_ADDR_W-1:0]  w_enc_addr;
  logic                   w_beat_done;
  logic                   w_accept;

  prienc_8_3 u_prienc (
    .i_vec  (r_pend),
    .o_addr (w_enc_addr)
  );

  // Decode beat fields from registered state only; match_vec never reaches the hit outputs.
  always_comb begin
    w_pend_rest = r_pend & (r_pend - 8'd1);
    w_iter_last = (w_pend_rest == '0);
    hit_valid   = (r_state != IDLE);
    hit_miss    = (r_state == MISS);
    hit_last    = (r_state == MISS) | ((r_state == ITER) & w_iter_last);
    hit_addr    = (r_state == ITER) ? w_enc_addr : '0;
    busy        = hit_valid;
    w_beat_done = hit_valid & hit_ready & hit_last;
    match_ready = (r_state == IDLE) | w_beat_done;
    w_accept    = match_valid & match_ready;
  end

  // Iterator FSM: a new vector may replace a finishing one in the same edge, so no bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_pend  <= '0;
    end else if (w_accept) begin
      if (match_vec != '0) begin
        r_pend  <= match_vec;
        r_state <= ITER;
      end else begin
        r_pend  <= '0;
        r_state <= EMIT_MISS ? MISS : IDLE;
      end
    end else if (w_beat_done) begin
      r_pend  <= '0;
      r_state <= IDLE;
    end else if ((r_state == ITER) && hit_ready) begin
      r_pend <= w_pend_rest;
    end
  end

`ifdef CAM_MATCH_COUNT_EN
  logic [3:0] r_match_cnt;

  // Remember how many entries matched in the last accepted vector.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_match_cnt <= 4'd0;
    end else if (w_accept) begin
      r_match_cnt <= popcnt8(match_vec);
    end
  end

  assign match_cnt = r_match_cnt;
`endif

endmodule

// File: tb/tb_cam_match_iter.sv
// Self-checking bench for cam_match_iter: directed scenarios with literal expectations
// plus a randomized run compared every cycle against a queue-of-beats model.
// Set CAM_MATCH_COUNT_EN to also check match_cnt.
module tb_cam_match_iter;

  logic       clk = 1'b0;
  logic       rst;
  logic       match_valid;
  logic       match_ready;
  logic [7:0] match_vec;
  logic       hit_valid;
  logic       hit_ready;
  logic [2:0] hit_addr;
  logic       hit_last;
  logic       hit_miss;
  logic       busy;

  logic       m0_valid;
  logic       m0_ready;
  logic [7:0] m0_vec;
  logic       h0_valid;
  logic       h0_ready;
  logic [2:0] h0_addr;
  logic       h0_last;
  logic       h0_miss;
  logic       busy0;

`ifdef CAM_MATCH_COUNT_EN
  logic [3:0] match_cnt;
  logic [3:0] match_cnt0;
`endif

  always #5 clk = ~clk;

  cam_match_iter #(.EMIT_MISS(1'b1)) dut (
    .clk         (clk),
    .rst         (rst),
    .match_valid (match_valid),
    .match_ready (match_ready),
    .match_vec   (match_vec),
    .hit_valid   (hit_valid),
    .hit_ready   (hit_ready),
    .hit_addr    (hit_addr),
    .hit_last    (hit_last),
    .hit_miss    (hit_miss),
    .busy        (busy)
`ifdef CAM_MATCH_COUNT_EN
    ,
    .match_cnt   (match_cnt)
`endif
  );

  cam_match_iter #(.EMIT_MISS(1'b0)) dut0 (
    .clk         (clk),
    .rst         (rst),
    .match_valid (m0_valid),
    .match_ready (m0_ready),
    .match_vec   (m0_vec),
    .hit_valid   (h0_valid),
    .hit_ready   (h0_ready),
    .hit_addr    (h0_addr),
    .hit_last    (h0_last),
    .hit_miss    (h0_miss),
    .busy        (busy0)
`ifdef CAM_MATCH_COUNT_EN
    ,
    .match_cnt   (match_cnt0)
`endif
  );

  typedef struct {
    int addr;
    int last;
    int miss;
    int cyc;
  } beat_t;

  beat_t exp_q[$];
  beat_t log_q[$];
  int    n_chk = 0;
  int    n_err = 0;
  int    cyc = 0;
  int    cnt_model = 0;
  bit    cmp_en = 1'b0;
  logic  exp_vld;
  logic  exp_rdy;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
    end
  endfunction

  // Expected beats for a vector: one per set bit ascending, last on the highest; a miss beat for zero.
  function automatic void push_vector(input logic [7:0] v);
    int hi;
    beat_t b;
    hi = -1;
    for (int i = 0; i < 8; i++) if (v[i]) hi = i;
    if (hi < 0) begin
      b.addr = 0; b.last = 1; b.miss = 1; b.cyc = 0;
      exp_q.push_back(b);
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (v[i]) begin
          b.addr = i; b.last = (i == hi) ? 1 : 0; b.miss = 0; b.cyc = 0;
          exp_q.push_back(b);
        end
      end
    end
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Compare outputs against the model, then advance the model to what the next edge commits.
  always @(negedge clk) begin
    if (cmp_en) begin
      exp_vld = (exp_q.size() != 0);
      chk("hit_valid", 32'(hit_valid), 32'(exp_vld));
      chk("busy", 32'(busy), 32'(exp_vld));
      if (exp_vld && hit_valid) begin
        chk("hit_addr", 32'(hit_addr), exp_q[0].addr);
        chk("hit_last", 32'(hit_last), exp_q[0].last);
        chk("hit_miss", 32'(hit_miss), exp_q[0].miss);
      end
      exp_rdy = !exp_vld || (hit_ready && (exp_q[0].last != 0));
      chk("match_ready", 32'(match_ready), 32'(exp_rdy));
`ifdef CAM_MATCH_COUNT_EN
      chk("match_cnt", 32'(match_cnt), cnt_model);
`endif
      if (rst) begin
        exp_q.delete();
        cnt_model = 0;
      end else begin
        if (exp_vld && hit_ready) begin
          beat_t b;
          b = exp_q.pop_front();
          b.addr = int'(hit_addr); b.last = int'(hit_last); b.miss = int'(hit_miss); b.cyc = cyc;
          log_q.push_back(b);
        end
        if (match_valid && exp_rdy) begin
          push_vector(match_vec);
          cnt_model = $countones(match_vec);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; match_valid = 1'b0; match_vec = 8'h00; hit_ready = 1'b0;
    m0_valid = 1'b0; m0_vec = 8'h00; h0_ready = 1'b1;
    tick();
    cmp_en = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    chk("rst_hit_valid", 32'(hit_valid), 0);
    chk("rst_hit_addr", 32'(hit_addr), 0);
    chk("rst_hit_last", 32'(hit_last), 0);
    chk("rst_hit_miss", 32'(hit_miss), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_match_ready", 32'(match_ready), 1);
    chk("rst0_match_ready", 32'(m0_ready), 1);
`ifdef CAM_MATCH_COUNT_EN
    chk("rst_match_cnt", 32'(match_cnt), 0);
    chk("rst0_match_cnt", 32'(match_cnt0), 0);
`endif

    // 1010_0110 with ready held high: 1,2,5,7 back to back
    log_q.delete();
    hit_ready = 1'b1; match_valid = 1'b1; match_vec = 8'hA6;
    tick();
    match_valid = 1'b0;
    repeat (6) tick();
    chk("a6_beats", log_q.size(), 4);
    if (log_q.size() == 4) begin
      chk("a6_addr0", log_q[0].addr, 1);
      chk("a6_addr1", log_q[1].addr, 2);
      chk("a6_addr2", log_q[2].addr, 5);
      chk("a6_addr3", log_q[3].addr, 7);
      chk("a6_last_early", log_q[0].last + log_q[1].last + log_q[2].last, 0);
      chk("a6_last3", log_q[3].last, 1);
      chk("a6_consecutive", log_q[3].cyc - log_q[0].cyc, 3);
    end
    chk("a6_busy_after", 32'(busy), 0);
`ifdef CAM_MATCH_COUNT_EN
    chk("a6_cnt", 32'(match_cnt), 4);
`endif

    // All-zero vector with miss beats enabled
    log_q.delete();
    match_valid = 1'b1; match_vec = 8'h00;
    tick();
    match_valid = 1'b0;
    repeat (3) tick();
    chk("miss_beats", log_q.size(), 1);
    if (log_q.size() == 1) begin
      chk("miss_addr", log_q[0].addr, 0);
      chk("miss_last", log_q[0].last, 1);
      chk("miss_flag", log_q[0].miss, 1);
    end

    // 0x81 with hit_ready toggling: 0 held through the stall, then 7 last
    log_q.delete();
    hit_ready = 1'b0; match_valid = 1'b1; match_vec = 8'h81;
    tick();
    match_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      hit_ready = (i % 2 == 1);
      if (i < 2) chk("stall_addr", 32'(hit_addr), 0);
      if (i == 0) chk("stall_last", 32'(hit_last), 0);
      if (i == 2) chk("h81_addr7", 32'(hit_addr), 7);
      tick();
    end
    hit_ready = 1'b1;
    chk("h81_beats", log_q.size(), 2);
    if (log_q.size() == 2) begin
      chk("h81_first", log_q[0].addr, 0);
      chk("h81_second", log_q[1].addr, 7);
      chk("h81_second_last", log_q[1].last, 1);
    end

    // Back-to-back single-bit vectors with no bubble
    log_q.delete();
    match_valid = 1'b1; match_vec = 8'h08;
    chk("b2b_ready0", 32'(match_ready), 1);
    tick();
    match_vec = 8'h40;
    chk("b2b_ready1", 32'(match_ready), 1);
    tick();
    match_valid = 1'b0;
    chk("b2b_addr6", 32'(hit_addr), 6);
    repeat (3) tick();
    chk("b2b_beats", log_q.size(), 2);
    if (log_q.size() == 2) begin
      chk("b2b_first", log_q[0].addr, 3);
      chk("b2b_second", log_q[1].addr, 6);
      chk("b2b_consecutive", log_q[1].cyc - log_q[0].cyc, 1);
    end

    // Reset after the first beat of 0xFF
    log_q.delete();
    match_valid = 1'b1; match_vec = 8'hFF;
    tick();
    match_valid = 1'b0;
`ifdef CAM_MATCH_COUNT_EN
    chk("ff_cnt_before", 32'(match_cnt), 8);
`endif
    chk("ff_first_addr", 32'(hit_addr), 0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("ff_rst_valid", 32'(hit_valid), 0);
    chk("ff_rst_busy", 32'(busy), 0);
`ifdef CAM_MATCH_COUNT_EN
    chk("ff_rst_cnt", 32'(match_cnt), 0);
`endif
    repeat (3) tick();
    chk("ff_beats", log_q.size(), 1);

    // Silent consumption of an all-zero vector when miss beats are disabled
    m0_valid = 1'b1; m0_vec = 8'h00;
    tick();
    m0_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("nomiss_valid", 32'(h0_valid), 0);
      chk("nomiss_busy", 32'(busy0), 0);
      chk("nomiss_ready", 32'(m0_ready), 1);
      tick();
    end
    m0_valid = 1'b1; m0_vec = 8'h05;
    tick();
    m0_valid = 1'b0;
    chk("nm05_valid", 32'(h0_valid), 1);
    chk("nm05_addr0", 32'(h0_addr), 0);
    chk("nm05_last0", 32'(h0_last), 0);
    chk("nm05_miss", 32'(h0_miss), 0);
    tick();
    chk("nm05_addr2", 32'(h0_addr), 2);
    chk("nm05_last2", 32'(h0_last), 1);
    tick();
    chk("nm05_done", 32'(h0_valid), 0);

    // Randomized traffic checked every cycle by the model
    for (int n = 0; n < 3000; n++) begin
      int sel;
      sel = $urandom % 4;
      match_valid = ($urandom % 3) != 0;
      if (sel == 0)      match_vec = 8'h00;
      else if (sel == 1) match_vec = 8'(1 << ($urandom % 8));
      else               match_vec = 8'($urandom);
      hit_ready = ($urandom % 4) != 0;
      rst = ($urandom % 200) == 0;
      tick();
    end
    rst = 1'b0; match_valid = 1'b0; hit_ready = 1'b1;
    repeat (12) tick();
    chk("drain_idle", 32'(busy), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/cam_match_iter.md
# cam_match_iter

Multi-match iterator between the CAM match-line stage and the address output. Accepts one 8-bit match vector per search and emits one beat per set bit, lowest index first, over a valid/ready stream. Each beat carries the 3-bit matching address, a last flag, and a miss flag. Lets the CAM report every matching entry rather than only the highest-priority one.

## Interface
- `EMIT_MISS`, default 1: 1 = an all-zero vector produces one miss beat; 0 = an all-zero vector is consumed silently.
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `match_valid`  in  1  match vector available.
- `match_ready`  out  1  block can accept a vector this cycle.
- `match_vec`  in  8  match lines; bit i set = entry i matched.
- `hit_valid`  out  1  output beat valid.
- `hit_ready`  in  1  consumer accepts beat.
- `hit_addr`  out  3  index of lowest remaining set bit; 0 on a miss beat.
- `hit_last`  out  1  final beat for the current vector.
- `hit_miss`  out  1  beat reports "no match".
- `busy`  out  1  state ≠ IDLE.

## Operation
- States: IDLE, ITER, MISS.
- Register `pend[7:0]` holds the match bits not yet emitted.
- IDLE
  - `match_ready`=1.
  - On `match_valid`: if `match_vec`≠0, load `pend`←`match_vec` and go to ITER.
  - If `match_vec`=0 and `EMIT_MISS`=1, go to MISS.
  - If `match_vec`=0 and `EMIT_MISS`=0, stay in IDLE.
- ITER
  - `hit_valid`=1.
  - `hit_addr` = lowest-set-bit index of `pend`.
  - `hit_last` = (`pend & (pend-1)`)==0.
  - `hit_miss`=0.
  - On `hit_ready`: `pend`←`pend & (pend-1)`. If `hit_last`, leave ITER.
- MISS
  - `hit_valid`=1, `hit_addr`=0, `hit_last`=1, `hit_miss`=1.
  - On `hit_ready`, leave MISS.
- Back-to-back: `match_ready` = IDLE | (`hit_valid` & `hit_ready` & `hit_last`).
  - A vector accepted in the same cycle as a last-beat handshake is loaded directly. Next state follows the IDLE rules for that vector; no bubble.
- Output fields stay stable while `hit_valid`=1 and `hit_ready`=0.
- `pend` is 8 bits; `pend-1` is computed in 8 bits. ITER is never entered with `pend`=0.

## Timing
- Reset values: state=IDLE, `pend`=0, `hit_valid`=0, `hit_addr`=0, `hit_last`=0, `hit_miss`=0, `busy`=0, `match_ready`=1 (combinational from IDLE).
- `rst` mid-iteration discards remaining bits. No further beats are emitted; state returns to IDLE in the next cycle.
- Latency: vector accepted at edge N → first beat valid in cycle N+1.
- A vector with k set bits (k≥1) takes exactly k handshakes. Minimum k cycles with `hit_ready` held high.
- Throughput with `hit_ready`=1: a new vector every k cycles (every 1 cycle for single-bit or miss vectors).
- `hit_addr`/`hit_last` are decoded combinationally from registered `pend`. No combinational path from `match_vec` to the hit outputs.
- `match_ready` depends combinationally on `hit_ready`.

## Configuration
- `CAM_MATCH_COUNT_EN` defined: adds output `match_cnt` (out, 4 bits).
  - Loaded with popcount of `match_vec` on every accepted vector, 0..8; 0 for an all-zero vector.
  - Holds that value until the next accepted vector; reset value 0.
- Macro undefined: port and popcount logic absent; remaining behaviour identical.

## Structure
- Shared package `cam_pkg`:
  - state enum `cam_iter_state_t` (IDLE, ITER, MISS);
  - constants `CAM_ENTRIES`=8 and `CAM_ADDR_W`=3.
- Sub-module: `prienc_8_3` (LSB-priority 8→3 encoder), instantiated on `pend` to produce `hit_addr`.

## Test plan
- `match_vec`=8'b1010_0110, `hit_ready`=1:
  - beats `hit_addr` 1, 2, 5, 7 in consecutive cycles;
  - `hit_last` only on 7; `busy` drops the cycle after.
- `match_vec`=8'h00, `EMIT_MISS`=1: one beat with `hit_miss`=1, `hit_addr`=0, `hit_last`=1.
- `match_vec`=8'h00, `EMIT_MISS`=0: no beat; `busy` stays 0.
- `match_vec`=8'h81, `hit_ready` toggled 0/1 each cycle:
  - `hit_addr`=0 held stable across stall cycles, then 7 with last.
- Back-to-back single-bit vectors 8'h08, 8'h40, `match_valid` and `hit_ready` held high:
  - beats 3 then 6 in consecutive cycles; `match_ready` high both cycles.
- `rst` pulsed after the first beat of 8'hFF:
  - next cycle `hit_valid`=0, `busy`=0;
  - `match_cnt`=0 (with `CAM_MATCH_COUNT_EN`, after showing 8 before reset).
